axi_rd_sched: RTL and testbench
===============================

Name: axi_rd_sched

Overview:
- Round-robin scheduler that shares the single AXI4 read master port (AR/R subset) among NUM_REQ tensorcore operand loaders (e.g. A, B, C matrix fetch).
- Exactly one burst is in flight at a time, since the port carries no AXI ID.
- Latches the winning request, drives AR until accepted, then steers R beats to the owning requester with a per-burst beat index.
- Checks that the returned beat count matches the requested burst length.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 256, AXI data width
- SEL_W, $clog2(NUM_REQ), requester index width

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester burst request
- req_base  in  NUM_REQ*ADDR_WIDTH  burst base address; slice i belongs to requester i
- req_burst_num  in  NUM_REQ*8  AXI arlen (beats-1), slice i
- req_burst_size  in  NUM_REQ*3  AXI arsize, slice i
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request latched
- rsp_valid  out  NUM_REQ  one-hot: beat for requester i is on rsp_data
- rsp_data  out  DATA_WIDTH  shared beat data
- rsp_last  out  1  final beat of the burst
- rsp_beat  out  8  beat index within the burst, 0-based
- busy  out  1  a burst is in progress (state != IDLE)
- cur_sel  out  SEL_W  owner of the current burst
- len_err  out  1  sticky beat-count mismatch flag; cleared only by reset
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arlen  out  8
- m_axi_arsize  out  3
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, cur_sel=0, beat_cnt=0, len_err=0. All valid/ready/pulse outputs are 0. AR payload registers are 0. m_axi_arburst=2'b01 always.
- A reset assertion mid-burst abandons the burst immediately. No outputs are produced for the remaining beats, and any stale beats that arrive after reset are ignored because state is IDLE.
- FSM states:
  - IDLE:
    - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
    - In the same cycle: latch base/len/size into AR registers, latch cur_sel, pulse req_ready[cur_sel], clear beat_cnt, go to ADDR.
    - Requester must hold req_valid and payload stable until its req_ready pulse. The pulse is its acknowledgement; it then deasserts or presents its next request.
  - ADDR:
    - m_axi_arvalid=1 with registered payload, which stays stable until m_axi_arready.
    - On arvalid&&arready, go to DATA.
    - First AR can be asserted no earlier than 1 cycle after the grant.
  - DATA:
    - m_axi_rready=1 (0 in all other states).
    - Each rvalid&&rready beat is passed combinationally: rsp_valid[cur_sel]=1, rsp_data=m_axi_rdata, rsp_last=m_axi_rlast, rsp_beat=beat_cnt. beat_cnt then increments.
    - If rlast arrives with beat_cnt != arlen, set len_err.
    - If beat_cnt == arlen and rlast=0, set len_err and keep accepting beats until rlast.
    - On the rlast beat: rr_ptr = cur_sel+1 (wrapping at NUM_REQ→0), go to IDLE.
- rsp_* outputs are 0 when there is no accepted beat. rsp_data may be don't-care when rsp_valid=0, but the bench checks 0.
- Minimum gap between bursts: 1 IDLE cycle.
- Simultaneous requests: only the arbitration winner gets req_ready. Losers stay pending and are not starved; every pending requester is served within NUM_REQ bursts.
- req_valid changes during ADDR/DATA are ignored until IDLE.
- arlen=0 is a single beat with rsp_beat=0 and rsp_last=1.
- beat_cnt is 8 bits and does not exceed 255 for legal traffic. On a protocol error it wraps to 0.

Test Plan:
- Single request: req_valid=3'b001, base=0x1000, num=3, size=5 → req_ready[0] pulses. Next cycle arvalid with araddr=0x1000, arlen=3, arsize=5. After arready, 4 beats route to rsp_valid[0] with rsp_beat 0..3, rsp_last on beat 3, len_err=0.
- All three requesting continuously → grant order 0,1,2,0,1,2. Each requester's beats appear only on its own rsp_valid bit.
- Backpressure: arready held low 5 cycles → araddr/arlen/arsize stay stable throughout, then DATA entered. rvalid gaps between beats → beat_cnt advances only on accepted beats.
- Length error: arlen=3 but rlast on beat index 1 → len_err=1 stays high, FSM returns to IDLE, next burst serviced normally. Separately, arlen=1 with rlast on index 3 → len_err=1, all 4 beats delivered.
- Reset mid-DATA after 2 of 8 beats → all outputs 0, state IDLE, rr_ptr=0. Residual rvalid beats produce no rsp_valid. New request granted normally.
- arlen=0 from requester 2 only → one beat with rsp_valid=3'b100, rsp_beat=0, rsp_last=1. rr_ptr wraps to 0.

Source files
------------

// File: rtl/axi_rd_sched.sv
// axi_rd_sched: round-robin arbiter sharing one AXI4 read port (AR/R only) among NUM_REQ
// operand loaders. One burst is in flight at a time; R beats are steered to the owner with
// a running beat index, and a sticky flag records any beat-count/arlen disagreement.
module axi_rd_sched #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned SEL_W      = $clog2(NUM_REQ)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [NUM_REQ*8-1:0]          req_burst_num,
  input  logic [NUM_REQ*3-1:0]          req_burst_size,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  output logic [7:0]                    rsp_beat,
  output logic                          busy,
  output logic [SEL_W-1:0]              cur_sel,
  output logic                          len_err,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
  localparam int unsigned ScanW = SEL_W + 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]        cur_sel_q, cur_sel_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]              ar_len_q, ar_len_d;
  logic [2:0]              ar_size_q, ar_size_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    len_err_q, len_err_d;

  logic                    grant_vld;
  logic [SEL_W-1:0]        grant_idx;
  logic [ScanW-1:0]        scan_pos;
  logic [SEL_W-1:0]        scan_idx;
  logic                    take_grant;
  logic                    beat_acc;

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_pos  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_pos = ScanW'(rr_ptr_q) + ScanW'(k);
      if (scan_pos >= ScanW'(NUM_REQ)) begin
        scan_pos = scan_pos - ScanW'(NUM_REQ);
      end
      scan_idx = scan_pos[SEL_W-1:0];
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign take_grant = (state_q == StIdle) && grant_vld;
  assign beat_acc   = (state_q == StData) && m_axi_rvalid;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant_vld) state_d = StAddr;
      StAddr:  if (m_axi_arready) state_d = StData;
      StData:  if (m_axi_rvalid && m_axi_rlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: grant latch, beat counter, length check, pointer advance.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cur_sel_d  = cur_sel_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    if (take_grant) begin
      cur_sel_d  = grant_idx;
      beat_cnt_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == SEL_W'(i)) begin
          ar_addr_d = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
          ar_len_d  = req_burst_num[i*8 +: 8];
          ar_size_d = req_burst_size[i*3 +: 3];
        end
      end
    end
    if (beat_acc) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      // rlast must coincide exactly with beat index == arlen; early or late both flag.
      if (m_axi_rlast != (beat_cnt_q == ar_len_q)) begin
        len_err_d = 1'b1;
      end
      if (m_axi_rlast) begin
        rr_ptr_d = (cur_sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : cur_sel_q + SEL_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr_q   <= '0;
      cur_sel_q  <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cur_sel_q  <= cur_sel_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  // Outputs: AR from registers, R beats passed straight through to the owner.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = take_grant && (grant_idx == SEL_W'(i));
      rsp_valid[i] = beat_acc && (cur_sel_q == SEL_W'(i));
    end
    rsp_data      = beat_acc ? m_axi_rdata : '0;
    rsp_last      = beat_acc && m_axi_rlast;
    rsp_beat      = beat_acc ? beat_cnt_q : 8'd0;
    busy          = (state_q != StIdle);
    cur_sel       = cur_sel_q;
    len_err       = len_err_q;
    m_axi_araddr  = ar_addr_q;
    m_axi_arlen   = ar_len_q;
    m_axi_arsize  = ar_size_q;
    m_axi_arburst = 2'b01;
    m_axi_arvalid = (state_q == StAddr);
    m_axi_rready  = (state_q == StData);
  end

endmodule

// File: tb/tb_axi_rd_sched.sv
// Bench for axi_rd_sched: transaction-level model of requesters, round-robin order and a
// memory-side slave with random AR stalls and R gaps; every output checked cycle by cycle.
module tb_axi_rd_sched;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = 2;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_base;
  logic [N*8-1:0]  req_burst_num;
  logic [N*3-1:0]  req_burst_size;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic [7:0]      rsp_beat;
  logic            busy;
  logic [SW-1:0]   cur_sel;
  logic            len_err;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  axi_rd_sched #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_valid     (req_valid),
    .req_base      (req_base),
    .req_burst_num (req_burst_num),
    .req_burst_size(req_burst_size),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_beat      (rsp_beat),
    .busy          (busy),
    .cur_sel       (cur_sel),
    .len_err       (len_err),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          rr;
  bit          err_m;
  bit          refill;
  int          max_len;
  logic [N-1:0] pend;
  logic [AW-1:0] m_base[N];
  logic [7:0]    m_num[N];
  logic [2:0]    m_size[N];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_base[i*AW +: AW]     = m_base[i];
      req_burst_num[i*8 +: 8]  = m_num[i];
      req_burst_size[i*3 +: 3] = m_size[i];
    end
    req_valid = pend;
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    m_base[i] = $urandom & 32'hFFFF_FFE0;
    m_num[i]  = 8'($urandom_range(0, max_len));
    m_size[i] = 3'($urandom_range(0, 5));
  endtask

  // Grant in the current IDLE cycle, then the AR handshake with a random stall.
  task automatic grant_addr(output int w, output logic [7:0] len);
    logic [AW-1:0] a;
    logic [2:0]    sz;
    int            stall;
    if (pend == '0) new_req($urandom_range(0, N - 1));
    drive_reqs();
    w = pick(pend, rr);
    sample();
    check_eq("grant", DW'(req_ready), DW'(1 << w));
    check_eq("idle_busy", DW'(busy), '0);
    check_eq("idle_arvalid", DW'(m_axi_arvalid), '0);
    check_eq("len_err", DW'(len_err), DW'(err_m));
    a   = m_base[w];
    len = m_num[w];
    sz  = m_size[w];
    step();
    if (refill) new_req(w);
    else pend[w] = 1'b0;
    drive_reqs();
    stall = $urandom_range(0, 5);
    m_axi_arready = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) m_axi_arready = 1'b1;
      sample();
      check_eq("arvalid", DW'(m_axi_arvalid), 1);
      check_eq("araddr", DW'(m_axi_araddr), DW'(a));
      check_eq("arlen", DW'(m_axi_arlen), DW'(len));
      check_eq("arsize", DW'(m_axi_arsize), DW'(sz));
      check_eq("arburst", DW'(m_axi_arburst), 1);
      check_eq("addr_cur_sel", DW'(cur_sel), DW'(w));
      check_eq("addr_busy", DW'(busy), 1);
      check_eq("addr_req_ready", DW'(req_ready), '0);
      check_eq("addr_rready", DW'(m_axi_rready), '0);
      step();
    end
    m_axi_arready = 1'b0;
  endtask

  // Deliver `beats` R beats with random gaps; rlast on the final one if asked.
  task automatic data_phase(input int w, input int beats, input bit last_on_final);
    for (int i = 0; i < beats; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      m_axi_rvalid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sample();
        check_eq("gap_rsp_valid", DW'(rsp_valid), '0);
        check_eq("gap_rsp_data", rsp_data, '0);
        check_eq("rready", DW'(m_axi_rready), 1);
        step();
      end
      m_axi_rvalid = 1'b1;
      for (int j = 0; j < DW / 32; j++) m_axi_rdata[j*32 +: 32] = $urandom;
      m_axi_rlast = last_on_final && (i == beats - 1);
      sample();
      check_eq("rsp_valid", DW'(rsp_valid), DW'(1 << w));
      check_eq("rsp_beat", DW'(rsp_beat), DW'(8'(i)));
      check_eq("rsp_last", DW'(rsp_last), DW'(m_axi_rlast));
      check_eq("rsp_data", rsp_data, m_axi_rdata);
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  // Full burst; nb < 0 means the slave returns exactly arlen+1 beats.
  task automatic burst(input int nb);
    int         w;
    logic [7:0] len;
    grant_addr(w, len);
    if (nb < 0) nb = int'(len) + 1;
    data_phase(w, nb, 1'b1);
    if (nb != int'(len) + 1) err_m = 1'b1;
    rr = (w + 1) % N;
  endtask

  initial begin
    int         w;
    logic [7:0] len;
    areset = 1'b1;
    req_valid = '0; req_base = '0; req_burst_num = '0; req_burst_size = '0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    rr = 0; err_m = 1'b0; refill = 1'b0; max_len = 7; pend = '0;
    for (int i = 0; i < N; i++) begin
      m_base[i] = '0; m_num[i] = '0; m_size[i] = '0;
    end
    sample();
    check_eq("rst_busy", DW'(busy), '0);
    check_eq("rst_arvalid", DW'(m_axi_arvalid), '0);
    check_eq("rst_araddr", DW'(m_axi_araddr), '0);
    check_eq("rst_arlen", DW'(m_axi_arlen), '0);
    check_eq("rst_arburst", DW'(m_axi_arburst), 1);
    check_eq("rst_rready", DW'(m_axi_rready), '0);
    check_eq("rst_cur_sel", DW'(cur_sel), '0);
    check_eq("rst_len_err", DW'(len_err), '0);
    step();
    areset = 1'b0;
    sample();
    check_eq("post_rst_req_ready", DW'(req_ready), '0);
    check_eq("post_rst_rsp_valid", DW'(rsp_valid), '0);
    step();

    // Single request from requester 0.
    pend = 3'b001; m_base[0] = 32'h1000; m_num[0] = 8'd3; m_size[0] = 3'd5;
    burst(-1);

    // All three requesting back to back.
    refill = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    for (int b = 0; b < 6; b++) burst(-1);
    refill = 1'b0;
    pend = '0;

    // Early rlast, then a clean burst with the flag still set.
    pend = 3'b010; m_base[1] = 32'h2000; m_num[1] = 8'd3; m_size[1] = 3'd4;
    burst(2);
    burst(-1);
    // Late rlast: arlen=1, four beats all delivered.
    pend = 3'b001; m_base[0] = 32'h3000; m_num[0] = 8'd1; m_size[0] = 3'd3;
    burst(4);

    // Reset in the middle of an 8-beat burst.
    pend = 3'b010; m_base[1] = 32'h4000; m_num[1] = 8'd7; m_size[1] = 3'd5;
    grant_addr(w, len);
    data_phase(w, 2, 1'b0);
    areset = 1'b1;
    m_axi_rvalid = 1'b1;
    sample();
    check_eq("midrst_rsp_valid", DW'(rsp_valid), '0);
    check_eq("midrst_busy", DW'(busy), '0);
    check_eq("midrst_rready", DW'(m_axi_rready), '0);
    check_eq("midrst_arvalid", DW'(m_axi_arvalid), '0);
    check_eq("midrst_cur_sel", DW'(cur_sel), '0);
    check_eq("midrst_len_err", DW'(len_err), '0);
    check_eq("midrst_araddr", DW'(m_axi_araddr), '0);
    step();
    areset = 1'b0;
    rr = 0;
    err_m = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_axi_rlast = (c == 3);
      sample();
      check_eq("stale_rsp_valid", DW'(rsp_valid), '0);
      check_eq("stale_busy", DW'(busy), '0);
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;

    // arlen=0 from requester 2; pointer then wraps so requester 0 wins next.
    pend = 3'b100; m_base[2] = 32'h5000; m_num[2] = 8'd0; m_size[2] = 3'd2;
    burst(-1);
    for (int i = 0; i < N; i++) new_req(i);
    burst(-1);
    pend = '0;

    // Randomised traffic with occasional length faults.
    max_len = 15;
    for (int t = 0; t < 30; t++) begin
      int         nb;
      refill = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      grant_addr(w, len);
      nb = int'(len) + 1;
      if ($urandom_range(0, 7) == 0) begin
        nb = $urandom_range(1, int'(len) + 3);
        if (nb == int'(len) + 1) nb = nb + 1;
      end
      data_phase(w, nb, 1'b1);
      if (nb != int'(len) + 1) err_m = 1'b1;
      rr = (w + 1) % N;
    end

    pend = '0;
    drive_reqs();
    sample();
    check_eq("final_len_err", DW'(len_err), DW'(err_m));
    check_eq("final_busy", DW'(busy), '0);
    check_eq("final_req_ready", DW'(req_ready), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
